// File: rtl/dup_tag_cam.sv
// dup_tag_cam: small registered CAM holding up to DEPTH tags of WIDTH bits.
// Each compare checks cmp_data against every valid tag. The results are
// registered: an active-low match, a per-entry hit vector and the index of the
// lowest-numbered hit. Writes drop values that are already stored. Otherwise
// they fill entries in round-robin order, so the oldest entry is replaced first.
//
// Ports:
//   clk, reset         clock; synchronous active-high reset
//   clr                flush: invalidate all entries
//   wr_en, wr_data     insert request and tag
//   cmp_en, cmp_data   compare request and value
//   match_n            registered, 0 = compare hit a valid entry
//   hit_vec            registered per-entry hit, bit i = entry i
//   hit_idx            registered lowest hit index (0 when no hit)
//   cmp_vld            registered, high one cycle after an accepted compare
//   wr_dup             registered, high one cycle after a dropped duplicate write
//   full, count        occupancy (full decoded from count)
//
// Handshake: there is no backpressure. cmp_en / wr_en are accepted on every
// rising edge where reset is low. cmp_vld qualifies match_n/hit_vec/hit_idx for
// exactly one cycle; those outputs then hold until the next accepted compare.
module dup_tag_cam #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4,
  localparam int IDXW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              cmp_en,
  input  logic [WIDTH-1:0]  cmp_data,
  output logic              match_n,
  output logic [DEPTH-1:0]  hit_vec,
  output logic [IDXW-1:0]   hit_idx,
  output logic              cmp_vld,
  output logic              wr_dup,
  output logic              full,
  output logic [IDXW:0]     count
);

  logic [WIDTH-1:0] tag_q [DEPTH];
  logic [WIDTH-1:0] tag_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [IDXW-1:0]  wp_q, wp_d;
  logic [IDXW:0]    count_q, count_d;
  logic             match_n_q, match_n_d;
  logic [DEPTH-1:0] hit_vec_q, hit_vec_d;
  logic [IDXW-1:0]  hit_idx_q, hit_idx_d;
  logic             cmp_vld_q, cmp_vld_d;
  logic             wr_dup_q, wr_dup_d;

  // Both comparators use pre-update state. A compare issued in the same cycle
  // as a write or clear therefore sees the old contents. The valid qualifier
  // keeps stale tags in flushed entries from matching.
  logic [DEPTH-1:0] eq_cmp;
  logic [DEPTH-1:0] eq_wr;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      eq_cmp[i] = valid_q[i] & (&(tag_q[i] ~^ cmp_data));
      eq_wr[i]  = valid_q[i] & (&(tag_q[i] ~^ wr_data));
    end
  end

  always_comb begin
    tag_d     = tag_q;
    valid_d   = valid_q;
    wp_d      = wp_q;
    count_d   = count_q;
    match_n_d = match_n_q;
    hit_vec_d = hit_vec_q;
    hit_idx_d = hit_idx_q;
    cmp_vld_d = cmp_en;
    wr_dup_d  = 1'b0;

    if (cmp_en) begin
      hit_vec_d = eq_cmp;
      match_n_d = ~|eq_cmp;
      hit_idx_d = '0;
      // Scan downward so that the lowest-numbered hit is the one kept.
      for (int i = DEPTH - 1; i >= 0; i--) begin
        if (eq_cmp[i]) hit_idx_d = IDXW'(i);
      end
    end

    if (clr) begin
      valid_d = '0;
      wp_d    = '0;
      count_d = '0;
    end else if (wr_en) begin
      if (|eq_wr) begin
        wr_dup_d = 1'b1;
      end else begin
        tag_d[wp_q]   = wr_data;
        valid_d[wp_q] = 1'b1;
        wp_d          = wp_q + IDXW'(1);  // wraps modulo DEPTH (power of two)
        // When the CAM is full, this overwrites the oldest entry and count holds.
        if (!valid_q[wp_q]) count_d = count_q + (IDXW+1)'(1);
      end
    end
  end

  // Tag storage needs no reset; every use is qualified by valid_q.
  always_ff @(posedge clk) begin
    if (!reset) tag_q <= tag_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= '0;
      wp_q      <= '0;
      count_q   <= '0;
      match_n_q <= 1'b1;
      hit_vec_q <= '0;
      hit_idx_q <= '0;
      cmp_vld_q <= 1'b0;
      wr_dup_q  <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      wp_q      <= wp_d;
      count_q   <= count_d;
      match_n_q <= match_n_d;
      hit_vec_q <= hit_vec_d;
      hit_idx_q <= hit_idx_d;
      cmp_vld_q <= cmp_vld_d;
      wr_dup_q  <= wr_dup_d;
    end
  end

  assign match_n = match_n_q;
  assign hit_vec = hit_vec_q;
  assign hit_idx = hit_idx_q;
  assign cmp_vld = cmp_vld_q;
  assign wr_dup  = wr_dup_q;
  assign count   = count_q;
  assign full    = (count_q == (IDXW+1)'(DEPTH));

endmodule

// File: tb/tb_dup_tag_cam.sv
module tb_dup_tag_cam;

  localparam int WIDTH = 6;
  localparam int DEPTH = 4;
  localparam int IDXW  = 2;
  localparam int W     = 1 + DEPTH + IDXW;  // {match_n, hit_vec, hit_idx}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset = 1'b1;
  logic             clr = 1'b0;
  logic             wr_en = 1'b0;
  logic [WIDTH-1:0] wr_data = '0;
  logic             cmp_en = 1'b0;
  logic [WIDTH-1:0] cmp_data = '0;
  logic             match_n;
  logic [DEPTH-1:0] hit_vec;
  logic [IDXW-1:0]  hit_idx;
  logic             cmp_vld;
  logic             wr_dup;
  logic             full;
  logic [IDXW:0]    count;

  dup_tag_cam #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .clr(clr),
    .wr_en(wr_en), .wr_data(wr_data),
    .cmp_en(cmp_en), .cmp_data(cmp_data),
    .match_n(match_n), .hit_vec(hit_vec), .hit_idx(hit_idx),
    .cmp_vld(cmp_vld), .wr_dup(wr_dup), .full(full), .count(count)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expected compare result per cmp_vld cycle.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (cmp_vld) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_cmp_vld: got cmp_vld=1 expected no pending compare at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        check("cmp_match_n", 32'(match_n), 32'(e[W-1]));
        check("cmp_hit_vec", 32'(hit_vec), 32'(e[W-2:IDXW]));
        check("cmp_hit_idx", 32'(hit_idx), 32'(e[IDXW-1:0]));
      end
    end
  end

  // ---------------- driver ----------------
  // Called at a negedge: apply inputs for one rising edge, return at the next negedge.
  // The expected compare result (hand-computed) is queued when the compare is accepted.
  task automatic cyc(input logic w, input logic [WIDTH-1:0] wd,
                     input logic c, input logic [WIDTH-1:0] cd,
                     input logic cl, input logic [W-1:0] exp_cmp);
    wr_en = w; wr_data = wd; cmp_en = c; cmp_data = cd; clr = cl;
    if (c && !reset) exp_q.push_back(exp_cmp);
    @(negedge clk);
    wr_en = 1'b0; cmp_en = 1'b0; clr = 1'b0;
  endtask

  task automatic wr(input logic [WIDTH-1:0] d);
    cyc(1'b1, d, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic cmp(input logic [WIDTH-1:0] d, input logic mn,
                     input logic [DEPTH-1:0] hv, input logic [IDXW-1:0] hi);
    cyc(1'b0, '0, 1'b1, d, 1'b0, {mn, hv, hi});
  endtask

  task automatic check_occ(input string name, input int c, input logic f);
    check({name, "_count"}, 32'(count), 32'(c));
    check({name, "_full"}, 32'(full), 32'(f));
  endtask

  task automatic check_reset_outs(input string name);
    check({name, "_match_n"}, 32'(match_n), 32'd1);
    check({name, "_hit_vec"}, 32'(hit_vec), 32'd0);
    check({name, "_hit_idx"}, 32'(hit_idx), 32'd0);
    check({name, "_cmp_vld"}, 32'(cmp_vld), 32'd0);
    check({name, "_wr_dup"},  32'(wr_dup),  32'd0);
    check_occ(name, 0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    @(negedge clk);
    reset = 1'b1;
    // A compare requested during reset must not be accepted.
    cyc(1'b1, 6'h15, 1'b1, 6'h00, 1'b0, '0);
    cyc(1'b0, '0, 1'b1, 6'h00, 1'b0, '0);
    reset = 1'b0;
    check_reset_outs("reset");

    // Empty CAM: compare 0x00 must miss even though tags are uninitialised.
    cmp(6'h00, 1'b1, 4'b0000, 2'd0);
    check_occ("empty", 0, 1'b0);

    wr(6'h15); wr(6'h2A); wr(6'h3F);
    check_occ("three", 3, 1'b0);
    cmp(6'h2A, 1'b0, 4'b0010, 2'd1);

    // Duplicate write is dropped.
    wr(6'h15);
    check("dup_flag", 32'(wr_dup), 32'd1);
    check_occ("dup", 3, 1'b0);
    // If wp had moved, 0x01 would land in entry 0 rather than entry 3.
    wr(6'h01);
    check("nodup_flag", 32'(wr_dup), 32'd0);
    check_occ("fill", 4, 1'b1);
    cmp(6'h01, 1'b0, 4'b1000, 2'd3);

    // Full: wp wraps to 0, so the oldest entry (0x15) is replaced.
    wr(6'h07);
    check_occ("overwrite", 4, 1'b1);
    cmp(6'h15, 1'b1, 4'b0000, 2'd0);
    cmp(6'h07, 1'b0, 4'b0001, 2'd0);

    // Same-cycle write and compare: the compare sees the old contents (entry 1 = 0x2A).
    cyc(1'b1, 6'h09, 1'b1, 6'h09, 1'b0, {1'b1, 4'b0000, 2'd0});
    cmp(6'h09, 1'b0, 4'b0010, 2'd1);

    // Duplicate at full leaves wp alone: the next write goes to entry 2.
    wr(6'h07);
    check("dup_full_flag", 32'(wr_dup), 32'd1);
    check_occ("dup_full", 4, 1'b1);
    wr(6'h2A);
    cmp(6'h2A, 1'b0, 4'b0100, 2'd2);
    cmp(6'h3F, 1'b1, 4'b0000, 2'd0);
    // Entries are now 0x07, 0x09, 0x2A, 0x01.

    // Clear together with a write and a compare: the compare uses pre-clear contents.
    cyc(1'b1, 6'h11, 1'b1, 6'h2A, 1'b1, {1'b0, 4'b0100, 2'd2});
    check("clr_wr_dup", 32'(wr_dup), 32'd0);
    check_occ("clr", 0, 1'b0);
    cmp(6'h11, 1'b1, 4'b0000, 2'd0);
    cmp(6'h2A, 1'b1, 4'b0000, 2'd0);

    // Stale zero tag in a flushed entry must not match.
    wr(6'h00);
    wr(6'h05);
    cmp(6'h05, 1'b0, 4'b0010, 2'd1);
    cmp(6'h00, 1'b0, 4'b0001, 2'd0);
    cyc(1'b0, '0, 1'b0, '0, 1'b1, '0);
    cmp(6'h00, 1'b1, 4'b0000, 2'd0);

    // Reset mid-stream, right after a hitting compare.
    wr(6'h05);
    check_occ("refill", 1, 1'b0);
    cmp(6'h05, 1'b0, 4'b0001, 2'd0);
    reset = 1'b1;
    cyc(1'b1, 6'h22, 1'b1, 6'h05, 1'b0, '0);
    reset = 1'b0;
    check_reset_outs("mid_reset");
    cmp(6'h05, 1'b1, 4'b0000, 2'd0);

    @(negedge clk);
    check("pending_expected", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
